// File: rtl/fetch_dispatch_fsm_pkg.sv
// -----------------------------------------------------------------------------
// fetch_dispatch_fsm_pkg
//   Shared constants for the fetch/dispatch control stage: opcode classes,
//   execution-unit indices, FSM state encoding and a small opcode decoder.
//   Imported by fetch_dispatch_fsm_if and fetch_dispatch_fsm.
// -----------------------------------------------------------------------------
package fetch_dispatch_fsm_pkg;

  // Opcode classes found in instruction[15:12]
  localparam logic [3:0] OP_ALUI = 4'h0;
  localparam logic [3:0] OP_ALUR = 4'h1;
  localparam logic [3:0] OP_LDST = 4'h2;
  localparam logic [3:0] OP_BR   = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Execution unit indices into exec_start / exec_done
  localparam int UNIT_ALUI = 0;
  localparam int UNIT_ALUR = 1;
  localparam int UNIT_LDST = 2;
  localparam int UNIT_BR   = 3;
  localparam int N_UNITS   = 4;

  // FSM state encoding
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_EXECUTE = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  typedef logic [3:0] opcode_t;
  typedef logic [1:0] unit_t;

  // One-hot start vector for an opcode; zero for HALT and illegal opcodes.
  function automatic logic [N_UNITS-1:0] op_to_start(input opcode_t op);
    logic [N_UNITS-1:0] oh;
    oh = '0;
    case (op)
      OP_ALUI: oh[UNIT_ALUI] = 1'b1;
      OP_ALUR: oh[UNIT_ALUR] = 1'b1;
      OP_LDST: oh[UNIT_LDST] = 1'b1;
      OP_BR:   oh[UNIT_BR]   = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // Unit index owning an executable opcode.
  function automatic unit_t op_to_unit(input opcode_t op);
    unit_t u;
    case (op)
      OP_ALUR: u = unit_t'(UNIT_ALUR);
      OP_LDST: u = unit_t'(UNIT_LDST);
      OP_BR:   u = unit_t'(UNIT_BR);
      default: u = unit_t'(UNIT_ALUI);
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fetch_dispatch_fsm_if.sv
// -----------------------------------------------------------------------------
// fetch_dispatch_fsm_if
//   Bundles the program-memory read bus and the execution-unit control bus.
//   master : fetch/dispatch stage (drives mem_rd, mem_addr, instruction,
//            exec_start; receives mem_ready, mem_rdata, exec_done, pc_load,
//            pc_load_val)
//   slave  : memory + execution units (the opposite directions)
// -----------------------------------------------------------------------------
interface fetch_dispatch_fsm_if
  import fetch_dispatch_fsm_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ready;
  logic [15:0]         mem_rdata;
  logic [15:0]         instruction;
  logic [N_UNITS-1:0]  exec_start;
  logic [N_UNITS-1:0]  exec_done;
  logic                pc_load;
  logic [ADDR_W-1:0]   pc_load_val;

  modport master (
    output mem_rd, mem_addr, instruction, exec_start,
    input  mem_ready, mem_rdata, exec_done, pc_load, pc_load_val
  );

  modport slave (
    input  mem_rd, mem_addr, instruction, exec_start,
    output mem_ready, mem_rdata, exec_done, pc_load, pc_load_val
  );

endinterface

// File: rtl/fetch_dispatch_fsm.sv
// -----------------------------------------------------------------------------
// fetch_dispatch_fsm
//   Upstream control stage: owns the PC, fetches 16-bit instructions, starts
//   exactly one execution unit per instruction and waits for its done.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   bus           fetch_dispatch_fsm_if.master (memory read bus, instruction,
//                 exec_start/exec_done, pc_load/pc_load_val)
//   pc            current program counter
//   busy          high in every state except HALT
//   halted        sticky halt indicator
//   illegal       sticky illegal-opcode indicator
//   wdt_trip      sticky execute-watchdog trip (only with FETCH_WDT_EN)
//
// Build option:
//   FETCH_WDT_EN  when defined, EXECUTE is bounded to WDT_CYCLES cycles; on
//                 expiry the stage halts and raises wdt_trip.
// -----------------------------------------------------------------------------
module fetch_dispatch_fsm
  import fetch_dispatch_fsm_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                WDT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_dispatch_fsm_if.master bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 halted,
`ifdef FETCH_WDT_EN
  output logic                 illegal,
  output logic                 wdt_trip
`else
  output logic                 illegal
`endif
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;
  unit_t             r_unit;
  logic              r_halted;
  logic              r_illegal;

  opcode_t           w_op;
  logic              w_is_exec;
  logic              w_done;
  logic              w_wdt_expire;

  assign w_op      = r_instr[15:12];
  assign w_is_exec = (w_op[3:2] == 2'b00);
  // Only the unit started for this instruction can complete it.
  assign w_done    = bus.exec_done[r_unit];

`ifdef FETCH_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [WDT_W-1:0] r_wdt;
  logic             r_wdt_trip;

  // Counts EXECUTE cycles spent waiting; cleared while in DECODE so it is
  // zero on the first EXECUTE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt <= '0;
    end else if (r_state == ST_DECODE) begin
      r_wdt <= '0;
    end else if (r_state == ST_EXECUTE && !w_done) begin
      r_wdt <= r_wdt + WDT_W'(1);
    end
  end

  assign w_wdt_expire = (r_state == ST_EXECUTE) && !w_done &&
                        (r_wdt == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt_trip <= 1'b0;
    end else if (w_wdt_expire) begin
      r_wdt_trip <= 1'b1;
    end
  end

  assign wdt_trip = r_wdt_trip;
`else
  assign w_wdt_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= 16'h0000;
      r_unit    <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            r_instr <= bus.mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_is_exec) begin
            r_unit  <= op_to_unit(w_op);
            r_state <= ST_EXECUTE;
          end else begin
            r_halted  <= 1'b1;
            r_illegal <= (w_op != OP_HALT);
            r_state   <= ST_HALT;
          end
        end
        ST_EXECUTE: begin
          // A branch overwrite replaces the increment done at fetch.
          if (bus.pc_load) begin
            r_pc <= bus.pc_load_val;
          end
          if (w_done) begin
            r_state <= ST_FETCH;
          end else if (w_wdt_expire) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  // mem_rd is gated by rst so it stays low while reset is held.
  assign bus.mem_rd      = (r_state == ST_FETCH) && !rst;
  assign bus.mem_addr    = r_pc;
  assign bus.instruction = r_instr;
  // Combinational from state so reset removes the start pulse immediately.
  assign bus.exec_start  = (r_state == ST_DECODE) ? op_to_start(w_op) : '0;

  assign pc      = r_pc;
  assign busy    = (r_state != ST_HALT);
  assign halted  = r_halted;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// -----------------------------------------------------------------------------
// tb_fetch_dispatch_fsm
//   Directed bench for fetch_dispatch_fsm. A main instance (RESET_PC=0) runs
//   against a memory array and a transaction-level reference model checked on
//   every falling edge; a second instance (RESET_PC=8'hFF) covers PC wrap and
//   reset in the middle of an instruction. Build with FETCH_WDT_EN to include
//   the watchdog scenarios.
// -----------------------------------------------------------------------------
module tb_fetch_dispatch_fsm;

  logic clk;
  logic rst;
  logic rst2;
  logic ready_en;
  logic ready2;

  logic [7:0] pc, pc2;
  logic busy, busy2, halted, halted2, illegal, illegal2;
`ifdef FETCH_WDT_EN
  logic wdt_trip, wdt_trip2;
  localparam int WDT = 64;
`endif

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_err    = 0;

  fetch_dispatch_fsm_if #(.ADDR_W(8)) bus ();
  fetch_dispatch_fsm_if #(.ADDR_W(8)) bus2 ();

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus.mem_ready  = ready_en;
  assign bus2.mem_rdata = 16'h0123;
  assign bus2.mem_ready = ready2;

  fetch_dispatch_fsm #(.ADDR_W(8), .RESET_PC(8'h00), .WDT_CYCLES(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
`ifdef FETCH_WDT_EN
    .illegal  (illegal),
    .wdt_trip (wdt_trip)
`else
    .illegal  (illegal)
`endif
  );

  fetch_dispatch_fsm #(.ADDR_W(8), .RESET_PC(8'hFF), .WDT_CYCLES(64)) dut2 (
    .clk      (clk),
    .rst      (rst2),
    .bus      (bus2),
    .pc       (pc2),
    .busy     (busy2),
    .halted   (halted2),
`ifdef FETCH_WDT_EN
    .illegal  (illegal2),
    .wdt_trip (wdt_trip2)
`else
    .illegal  (illegal2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- reference model for the main instance ----------------
  typedef enum {M_FETCH, M_DECODE, M_EXEC, M_HALT} mphase_t;
  mphase_t     m_ph;
  logic [7:0]  m_pc;
  logic [15:0] m_ins;
  int          m_unit;
  int          m_wait;
  logic        m_halt, m_ill;
`ifdef FETCH_WDT_EN
  logic        m_trip;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= M_FETCH;
      m_pc   <= 8'h00;
      m_ins  <= 16'h0000;
      m_unit <= 0;
      m_wait <= 0;
      m_halt <= 1'b0;
      m_ill  <= 1'b0;
`ifdef FETCH_WDT_EN
      m_trip <= 1'b0;
`endif
    end else begin
      case (m_ph)
        M_FETCH: if (ready_en) begin
          m_ins <= mem[m_pc];
          m_pc  <= m_pc + 8'd1;
          m_ph  <= M_DECODE;
        end
        M_DECODE: begin
          if (m_ins[15:12] <= 4'd3) begin
            m_unit <= int'(m_ins[15:12]);
            m_wait <= 0;
            m_ph   <= M_EXEC;
          end else begin
            m_halt <= 1'b1;
            m_ill  <= (m_ins[15:12] != 4'hF);
            m_ph   <= M_HALT;
          end
        end
        M_EXEC: begin
          if (bus.pc_load) m_pc <= bus.pc_load_val;
          if (bus.exec_done[m_unit]) begin
            m_ph <= M_FETCH;
          end else begin
            m_wait <= m_wait + 1;
`ifdef FETCH_WDT_EN
            if (m_wait + 1 >= WDT) begin
              m_ph   <= M_HALT;
              m_halt <= 1'b1;
              m_trip <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0] op;
    op = m_ins[15:12];
    check("mem_rd", {31'd0, bus.mem_rd}, {31'd0, (m_ph == M_FETCH) && !rst});
    if (bus.mem_rd) check("mem_addr", {24'd0, bus.mem_addr}, {24'd0, m_pc});
    check("exec_start", {28'd0, bus.exec_start},
          (m_ph == M_DECODE && op <= 4'd3) ? (32'd1 << op) : 32'd0);
    check("instruction", {16'd0, bus.instruction}, {16'd0, m_ins});
    check("pc", {24'd0, pc}, {24'd0, m_pc});
    check("busy", {31'd0, busy}, {31'd0, m_ph != M_HALT});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
`ifdef FETCH_WDT_EN
    check("wdt_trip", {31'd0, wdt_trip}, {31'd0, m_trip});
`endif
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; rst2 = 1'b1; ready_en = 1'b0; ready2 = 1'b0;
    bus.exec_done = 4'b0; bus.pc_load = 1'b0; bus.pc_load_val = 8'h00;
    bus2.exec_done = 4'b0; bus2.pc_load = 1'b0; bus2.pc_load_val = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0044; mem[1] = 16'h1234; mem[2] = 16'h2ABC;
    mem[3] = 16'h0001; mem[4] = 16'h1002; mem[5] = 16'h3000;
    mem[8'h20] = 16'hF000;

    step(2);
    check("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'h00);
    check("rst_instr", {16'd0, bus.instruction}, 32'h0000);
    check("rst_start", {28'd0, bus.exec_start}, 32'd0);
    check("rst_flags", {30'd0, halted, illegal}, 32'd0);

    // First fetch with memory ready immediately
    rst = 1'b0; ready_en = 1'b1;
    step(1);
    check("f0_instr", {16'd0, bus.instruction}, 32'h0044);
    check("f0_pc", {24'd0, pc}, 32'h01);
    check("f0_start", {28'd0, bus.exec_start}, 32'b0001);
    bus.exec_done = 4'b0001;
    step(1);
    check("f0_start_gone", {28'd0, bus.exec_start}, 32'd0);
    step(1);
    check("f1_rd", {31'd0, bus.mem_rd}, 32'd1);
    check("f1_addr", {24'd0, bus.mem_addr}, 32'h01);

    // Memory wait states
    ready_en = 1'b0; bus.exec_done = 4'b0;
    step(3);
    check("wait_addr", {24'd0, bus.mem_addr}, 32'h01);
    check("wait_instr", {16'd0, bus.instruction}, 32'h0044);
    ready_en = 1'b1;
    step(1);
    check("f1_instr", {16'd0, bus.instruction}, 32'h1234);
    check("f1_start", {28'd0, bus.exec_start}, 32'b0010);
    step(3);
    check("exec_wait_busy", {31'd0, busy}, 32'd1);
    bus.exec_done = 4'b0010;
    step(1);

    // Back-to-back minimum-period instructions at 2,3,4
    bus.exec_done = 4'b1111;
    step(9);
    check("f5_addr", {24'd0, bus.mem_addr}, 32'h05);

    // Branch with overwrite; spurious done from another unit ignored
    bus.exec_done = 4'b0000;
    step(1);
    check("br_start", {28'd0, bus.exec_start}, 32'b1000);
    step(1);
    bus.exec_done = 4'b0001; bus.pc_load = 1'b1; bus.pc_load_val = 8'h10;
    step(1);
    check("br_pc_mid", {24'd0, pc}, 32'h10);
    check("br_still_exec", {31'd0, bus.mem_rd}, 32'd0);
    bus.pc_load_val = 8'h20; bus.exec_done = 4'b1001;
    step(1);
    check("br_target", {24'd0, bus.mem_addr}, 32'h20);

    // pc_load outside EXECUTE is ignored; HALT opcode
    bus.pc_load_val = 8'h55; bus.exec_done = 4'b0000;
    step(2);
    bus.pc_load = 1'b0;
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_ill", {31'd0, illegal}, 32'd0);
    check("halt_pc", {24'd0, pc}, 32'h21);
    bus.exec_done = 4'b1111;
    step(20);
    check("halt_stays", {29'd0, bus.mem_rd, busy, halted}, 32'b001);

    // Illegal opcode after a fresh reset
    bus.exec_done = 4'b0000;
    rst = 1'b1;
    #1;
    check("rst2_pc", {24'd0, pc}, 32'h00);
    check("rst2_flags", {30'd0, halted, illegal}, 32'd0);
    mem[0] = 16'h7000;
    step(1);
    rst = 1'b0;
    step(2);
    check("ill_flags", {29'd0, busy, halted, illegal}, 32'b011);

`ifdef FETCH_WDT_EN
    // Watchdog trip: unit 1 never completes
    rst = 1'b1; mem[0] = 16'h1000;
    step(1);
    rst = 1'b0;
    step(2);
    step(63);
    check("wdt_pre", {30'd0, busy, wdt_trip}, 32'b10);
    step(1);
    check("wdt_trip", {29'd0, wdt_trip, halted, illegal}, 32'b110);
    // Done on the 63rd cycle: no trip
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    step(62);
    bus.exec_done = 4'b0010;
    step(1);
    bus.exec_done = 4'b0000;
    check("wdt_notrip", {30'd0, busy, wdt_trip}, 32'b10);
    check("wdt_next_addr", {24'd0, bus.mem_addr}, 32'h01);
`endif

    // Second instance: PC wrap and asynchronous reset mid-instruction
    rst2 = 1'b0; ready2 = 1'b1;
    step(1);
    check("wrap_pc", {24'd0, pc2}, 32'h00);
    check("wrap_instr", {16'd0, bus2.instruction}, 32'h0123);
    check("wrap_start", {28'd0, bus2.exec_start}, 32'b0001);
    rst2 = 1'b1;
    #1;
    check("async_start_drop", {28'd0, bus2.exec_start}, 32'd0);
    check("async_pc", {24'd0, pc2}, 32'hFF);
    step(1);
    rst2 = 1'b0;
    step(2);
    check("exec2_start", {28'd0, bus2.exec_start}, 32'd0);
    check("exec2_busy", {31'd0, busy2}, 32'd1);
    #1;
    rst2 = 1'b1;
    #1;
    check("midexec_pc", {24'd0, pc2}, 32'hFF);
    check("midexec_instr", {16'd0, bus2.instruction}, 32'h0000);
    check("midexec_rd", {31'd0, bus2.mem_rd}, 32'd0);
    step(1);
    rst2 = 1'b0;
    #1;
    check("refetch_rd", {31'd0, bus2.mem_rd}, 32'd1);
    check("refetch_addr", {24'd0, bus2.mem_addr}, 32'hFF);
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
